// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//  Shared definitions for the calculator instruction sequencer: default
//  widths, opcode constants, the sequencer state enum and the bit positions
//  of each field inside the 8-bit instruction word.
//
//  Instruction word layout: {op[1:0], ra[1:0], f3[1:0], f2[1:0]}
//    immd = {f3, f2}, rb = f3, rc = f2
// ---------------------------------------------------------------------------
package seq_pkg;

  localparam int SEQ_DW = 8;   // register / data width
  localparam int SEQ_AW = 2;   // register address width (fixed by encoding)

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  // Field slices of inst_wd
  localparam int OP_HI = 7;
  localparam int OP_LO = 6;
  localparam int RA_HI = 5;
  localparam int RA_LO = 4;
  localparam int F3_HI = 3;
  localparam int F3_LO = 2;
  localparam int F2_HI = 1;
  localparam int F2_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for an instruction, inst_rdy high
    ST_WB   = 2'd1,  // register write-back, retire
    ST_MUL  = 2'd2,  // multiplier iterating
    ST_TX   = 2'd3   // presenting a byte to the UART
  } seq_state_e;

endpackage

// File: rtl/seq_mul.sv
// ---------------------------------------------------------------------------
// seq_mul
//  Iterative shift-add multiplier. A start pulse loads the operands; the
//  unit then runs exactly DW iterations (no early exit when the multiplier
//  runs out of set bits) and keeps only the low DW bits of the product.
//
//  Ports
//    clk    in   clock, rising edge
//    rst_n  in   asynchronous active-low reset
//    start  in   one-cycle pulse: load a, b and begin
//    a      in   DW  multiplicand
//    b      in   DW  multiplier
//    done   out  high during the final iteration cycle; prod holds the
//                finished product from the following cycle on
//    prod   out  DW  accumulator (low DW bits of a*b once finished)
// ---------------------------------------------------------------------------
module seq_mul #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          done,
  output logic [DW-1:0] prod
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic          busy;
  logic [CW-1:0] cnt;
  logic [DW-1:0] mcand;
  logic [DW-1:0] mplr;
  logic [DW-1:0] acc;

  // The last iteration is the one with cnt == DW-1; signalling it one cycle
  // early lets the controller step to write-back on the same edge that
  // produces the final accumulator value.
  assign done = busy && (cnt == CW'(DW - 1));
  assign prod = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      mplr  <= b;
      acc   <= '0;
    end else if (busy) begin
      if (mplr[0]) begin
        acc <= acc + mcand;
      end
      // Bits shifted out of mcand only affect discarded upper product bits.
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// ---------------------------------------------------------------------------
// seq_ctrl
//  Instruction sequencer for the 4-register calculator datapath. Accepts one
//  decoded instruction word per inst_vld pulse, executes PUSH / ADD / MULT /
//  SEND, owns the register file and drives the led value and the UART byte
//  handshake.
//
//  Handshakes:
//    inst_vld/inst_rdy : an instruction transfers on a rising edge where both
//                        are high. inst_rdy is high only in IDLE; a pulse while
//                        inst_rdy is low is dropped, never queued.
//    tx_vld/tx_rdy     : a byte transfers on a rising edge where both are high.
//                        Once raised, tx_vld stays high and tx_data stays
//                        stable until that transfer.
//
//  Ports
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    inst_vld   in   instruction valid pulse
//    inst_wd    in   8   {op, ra, f3, f2}
//    inst_rdy   out  high only in IDLE
//    inst_done  out  one-cycle pulse when the accepted instruction retires
//    tx_vld     out  UART byte valid
//    tx_data    out  DW  rf[ra] captured when SEND was accepted
//    tx_rdy     in   UART transmitter ready
//    led        out  DW  value of the most recent register write-back
//    dbg_state  out  current sequencer state
// ---------------------------------------------------------------------------
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int DW = SEQ_DW,
  parameter int AW = SEQ_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inst_vld,
  input  logic [7:0]    inst_wd,
  output logic          inst_rdy,
  output logic          inst_done,
  output logic          tx_vld,
  output logic [DW-1:0] tx_data,
  input  logic          tx_rdy,
  output logic [DW-1:0] led,
  output seq_state_e    dbg_state
);

  localparam int NREG = 1 << AW;

  seq_state_e state;
  seq_state_e state_nxt;

  logic [DW-1:0] rf [NREG];

  // Decoded fields of the word currently on inst_wd
  logic [1:0]    op_w;
  logic [AW-1:0] ra_w;
  logic [AW-1:0] rb_w;
  logic [AW-1:0] rc_w;
  logic [DW-1:0] immd_w;

  // Instruction context captured at accept
  logic [1:0]    op_q;
  logic [AW-1:0] ra_q;
  logic [DW-1:0] res_q;

  logic          accept;
  logic          mul_start;
  logic          mul_done;
  logic [DW-1:0] mul_prod;
  logic [DW-1:0] wb_val;

  assign op_w   = inst_wd[OP_HI:OP_LO];
  assign ra_w   = inst_wd[RA_HI:RA_LO];
  assign rb_w   = inst_wd[F3_HI:F3_LO];
  assign rc_w   = inst_wd[F2_HI:F2_LO];
  assign immd_w = DW'(inst_wd[F3_HI:F2_LO]);

  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    inst_rdy  = 1'b0;
    inst_done = 1'b0;
    tx_vld    = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        inst_rdy = 1'b1;
        if (inst_vld) begin
          accept = 1'b1;
          case (op_w)
            OP_MULT: state_nxt = ST_MUL;
            OP_SEND: state_nxt = ST_TX;
            default: state_nxt = ST_WB;
          endcase
        end
      end
      ST_WB: begin
        inst_done = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_MUL: begin
        if (mul_done) begin
          state_nxt = ST_WB;
        end
      end
      ST_TX: begin
        tx_vld = 1'b1;
        if (tx_rdy) begin
          inst_done = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mul_start = accept && (op_w == OP_MULT);

  // Operands come straight from the register file at the accept edge, so a
  // destination that aliases a source still sees the old value.
  seq_mul #(
    .DW (DW)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (rf[rb_w]),
    .b     (rf[rc_w]),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign wb_val = (op_q == OP_MULT) ? mul_prod : res_q;

  // ---------------------------------------------------------------------
  // Datapath: instruction capture, register file, led, UART byte
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_PUSH;
      ra_q    <= '0;
      res_q   <= '0;
      tx_data <= '0;
      led     <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (accept) begin
        op_q <= op_w;
        ra_q <= ra_w;
        case (op_w)
          OP_PUSH: res_q   <= immd_w;
          OP_ADD:  res_q   <= rf[rb_w] + rf[rc_w];
          OP_SEND: tx_data <= rf[ra_w];
          default: ;
        endcase
      end
      if (state == ST_WB) begin
        rf[ra_q] <= wb_val;
        led      <= wb_val;
      end
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_ctrl
//  Scoreboard bench for seq_ctrl. The driver issues instructions, updates an
//  arithmetic model of the register file and pushes the expected retirement
//  (value, and for write-backs the retire cycle) into exp_q; a monitor pops
//  an entry on every inst_done and compares.
// ---------------------------------------------------------------------------
module tb_seq_ctrl;
  import seq_pkg::*;

  localparam int DW = 8;
  // exp_q entry: {is_send[1], value[8], retire_cycle[32]}
  localparam int W  = 41;

  logic          clk;
  logic          rst_n;
  logic          inst_vld;
  logic [7:0]    inst_wd;
  logic          inst_rdy;
  logic          inst_done;
  logic          tx_vld;
  logic [DW-1:0] tx_data;
  logic          tx_rdy;
  logic [DW-1:0] led;
  seq_state_e    dbg_state;

  logic [W-1:0] exp_q[$];
  int           model_rf[4];
  int           checks;
  int           fails;
  int           cyc;
  bit           rand_tx;

  seq_ctrl #(.DW(DW), .AW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_vld  (inst_vld),
    .inst_wd   (inst_wd),
    .inst_rdy  (inst_rdy),
    .inst_done (inst_done),
    .tx_vld    (tx_vld),
    .tx_data   (tx_data),
    .tx_rdy    (tx_rdy),
    .led       (led),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Random UART back-pressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_tx) tx_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [7:0] wd);
    int op, ra, rb, rc, val, lat, n;
    logic [W-1:0] e;
    n = 0;
    while (!inst_rdy && n < 200) begin
      step(1);
      n++;
    end
    if (!inst_rdy) begin
      checks++;
      fails++;
      $display("FAIL issue_wait: inst_rdy=%0b, expected 1 within 200 cycles", inst_rdy);
      return;
    end
    op = int'(wd[7:6]);
    ra = int'(wd[5:4]);
    rb = int'(wd[3:2]);
    rc = int'(wd[1:0]);
    val = 0;
    case (op)
      0: begin val = int'(wd[3:0]);                            model_rf[ra] = val; end
      1: begin val = (model_rf[rb] + model_rf[rc]) % 256;      model_rf[ra] = val; end
      2: begin val = (model_rf[rb] * model_rf[rc]) % 256;      model_rf[ra] = val; end
      default: val = model_rf[ra];
    endcase
    lat = (op == 2) ? DW + 1 : 1;
    e = {(op == 3), 8'(val), 32'(cyc + lat)};
    exp_q.push_back(e);
    inst_vld = 1'b1;
    inst_wd  = wd;
    step(1);
    inst_vld = 1'b0;
    inst_wd  = 8'h00;
  endtask

  // Pulse inst_vld while the sequencer is busy; nothing is expected from it.
  task automatic pulse_busy(input logic [7:0] wd);
    chk("busy_rdy_low", 32'(inst_rdy), 32'd0);
    inst_vld = 1'b1;
    inst_wd  = wd;
    step(1);
    inst_vld = 1'b0;
    inst_wd  = 8'h00;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_done) begin
        chk("done_rdy_overlap", 32'(inst_rdy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: inst_done=1 with no instruction outstanding (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          if (e[40]) begin
            chk("send_handshake", {30'd0, tx_vld, tx_rdy}, 32'd3);
            chk("send_data", 32'(tx_data), 32'(e[39:32]));
          end else begin
            chk("retire_cycle", 32'(cyc), e[31:0]);
            step(1);
            chk("led_writeback", 32'(led), 32'(e[39:32]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    checks   = 0;
    fails    = 0;
    rand_tx  = 1'b0;
    inst_vld = 1'b0;
    inst_wd  = 8'h00;
    tx_rdy   = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 4; i++) model_rf[i] = 0;

    #1;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_tx_vld", 32'(tx_vld), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_done", 32'(inst_done), 32'd0);
    chk("rst_rdy", 32'(inst_rdy), 32'd1);
    step(3);
    rst_n = 1'b1;
    step(1);

    // T1 / T2 / T3: PUSH, MULT, aliasing MULT then ADD
    issue(8'h04);
    issue(8'h04);
    issue(8'h13);
    issue(8'hA1);
    issue(8'h0F);
    issue(8'h80);
    issue(8'h70);
    issue(8'h04);   // r0 back to 4
    issue(8'hA1);   // r2 = 4*3 = 0x0C

    // T4 / T5: SEND r2 stalled 20 cycles, ignored pulse during the stall
    n = 0;
    while (!inst_rdy && n < 50) begin step(1); n++; end
    rand_tx = 1'b0;
    tx_rdy  = 1'b0;
    issue(8'hE0);
    for (int i = 0; i < 20; i++) begin
      chk("stall_tx_vld", 32'(tx_vld), 32'd1);
      chk("stall_tx_data", 32'(tx_data), 32'h0C);
      chk("stall_rdy", 32'(inst_rdy), 32'd0);
      if (i == 5) pulse_busy(8'h2F);
      else step(1);
    end
    tx_rdy = 1'b1;
    step(1);
    tx_rdy = 1'b0;
    chk("post_tx_vld", 32'(tx_vld), 32'd0);
    chk("post_tx_rdy", 32'(inst_rdy), 32'd1);
    rand_tx = 1'b1;
    issue(8'hE0);   // r2 must still be 0x0C

    // T5: pulse during MUL
    issue(8'h83);   // MULT r0 = r0*r3
    step(2);
    pulse_busy(8'h3F);
    issue(8'hF0);   // SEND r3
    issue(8'hC0);   // SEND r0

    // T6: reset in the middle of a MULT
    issue(8'hA1);
    step(3);
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) model_rf[i] = 0;
    #1;
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_tx_vld", 32'(tx_vld), 32'd0);
    chk("mid_rst_done", 32'(inst_done), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("mid_rst_rdy", 32'(inst_rdy), 32'd1);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    for (int r = 0; r < 4; r++) issue({2'b11, 2'(r), 4'h0});

    // Random instruction stream
    for (int k = 0; k < 200; k++) begin
      issue(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) step($urandom_range(1, 3));
    end

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin step(1); n++; end
    step(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
